frame_ecc_monitor: RTL and testbench

- Sequential post-processor for the 7-series frame ECC primitive outputs (CRCERROR, ECCERROR, ECCERRORSINGLE, FAR, SYNBIT, SYNWORD, SYNDROMEVALID).
- Classifies each syndrome event and logs it into a parametrised FIFO.
- Keeps saturating error counters.
- Issues a single-outstanding correction request (frame/word/bit) to a downstream ICAP read-modify-write scrubber via a req/ack handshake.

---
 rtl/frame_ecc_monitor.sv | 100 ++++++++++
 tb/tb_frame_ecc_monitor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/frame_ecc_monitor.sv
// frame_ecc_monitor: classifies frame ECC syndromes, logs them, counts errors and requests single-bit corrections
module frame_ecc_monitor #(
  parameter int FAR_W       = 26,
  parameter int LOG_DEPTH   = 8,
  parameter int CNT_W       = 16,
  parameter int FRAME_WORDS = 101
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 eccerror,
  input  logic                 eccerrorsingle,
  input  logic                 crcerror,
  input  logic [FAR_W-1:0]     far,
  input  logic [4:0]           synbit,
  input  logic [6:0]           synword,
  input  logic                 syndromevalid,
  input  logic                 clr,
  output logic [FAR_W+13:0]    log_data,
  output logic                 log_valid,
  input  logic                 log_rdy,
  output logic                 log_full,
  output logic                 log_ovf,
  output logic [CNT_W-1:0]     single_cnt,
  output logic [CNT_W-1:0]     multi_cnt,
  output logic [CNT_W-1:0]     crc_cnt,
  output logic                 corr_req,
  output logic [FAR_W-1:0]     corr_far,
  output logic [6:0]           corr_word,
  output logic [4:0]           corr_bit,
  input  logic                 corr_ack,
  output logic                 corr_drop,
  output logic                 uncorr
);
  localparam int AW = $clog2(LOG_DEPTH);
  localparam logic [6:0] FW = 7'(FRAME_WORDS);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, nxt;
  logic [FAR_W+13:0] mem [LOG_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [1:0] typ;
  logic ev, single, multi, pop, push, crc_q, crc_rise, load;
  assign ev        = syndromevalid & eccerror;
  assign typ       = !eccerrorsingle ? 2'b10 : (synword < FW) ? 2'b01 : 2'b11;
  assign single    = ev & (typ == 2'b01);
  assign multi     = ev & typ[1];
  assign log_valid = cnt != '0;
  assign log_full  = cnt == (AW+1)'(LOG_DEPTH);
  assign pop       = log_valid & log_rdy;
  assign push      = ev & (!log_full | pop);
  assign log_data  = log_valid ? mem[rp] : '0;
  assign crc_rise  = crcerror & ~crc_q;
  assign corr_req  = state == REQ;
  assign load      = (state == IDLE) & single;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c, input logic inc, input logic z);
    return z ? CNT_W'(inc) : (inc && !(&c)) ? c + 1'b1 : c;
  endfunction
  always_comb begin
    nxt = (state == IDLE) ? (single ? REQ : IDLE) : (corr_ack ? IDLE : REQ);
  end
  // Log storage needs no reset: log_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {typ, far, synword, synbit};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wp         <= '0;
      rp         <= '0;
      cnt        <= '0;
      crc_q      <= 1'b0;
      single_cnt <= '0;
      multi_cnt  <= '0;
      crc_cnt    <= '0;
      log_ovf    <= 1'b0;
      uncorr     <= 1'b0;
      corr_drop  <= 1'b0;
      corr_far   <= '0;
      corr_word  <= '0;
      corr_bit   <= '0;
    end else begin
      state      <= nxt;
      crc_q      <= crcerror;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt        <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      single_cnt <= sat(single_cnt, single, clr);
      multi_cnt  <= sat(multi_cnt, multi, clr);
      crc_cnt    <= sat(crc_cnt, crc_rise, clr);
      log_ovf    <= (log_ovf & ~clr) | (ev & ~push);
      uncorr     <= (uncorr & ~clr) | multi;
      corr_drop  <= (corr_drop & ~clr) | (single & (state == REQ));
      if (load) begin
        corr_far  <= far;
        corr_word <= synword;
        corr_bit  <= synbit;
      end
    end
  end
endmodule

// File: tb/tb_frame_ecc_monitor.sv
// tb_frame_ecc_monitor: directed checks of logging, counters, correction handshake and reset
module tb_frame_ecc_monitor;
  logic clk = 0, rst_n = 0;
  logic eccerror = 0, eccerrorsingle = 0, crcerror = 0, syndromevalid = 0, clr = 0;
  logic log_rdy = 0, corr_ack = 0;
  logic [25:0] far = 0;
  logic [4:0] synbit = 0;
  logic [6:0] synword = 0;
  logic [39:0] log_data, d4_log_data;
  logic log_valid, log_full, log_ovf, corr_req, corr_drop, uncorr;
  logic d4_log_valid, d4_log_full, d4_log_ovf, d4_corr_req, d4_corr_drop, d4_uncorr;
  logic [15:0] single_cnt, multi_cnt, crc_cnt;
  logic [3:0] s4_cnt, d4_multi_cnt, d4_crc_cnt;
  logic [25:0] corr_far, d4_corr_far;
  logic [6:0] corr_word, d4_corr_word;
  logic [4:0] corr_bit, d4_corr_bit;
  int passes = 0, total = 0;

  always #5 clk = ~clk;

  frame_ecc_monitor dut (
    .clk(clk), .rst_n(rst_n), .eccerror(eccerror), .eccerrorsingle(eccerrorsingle),
    .crcerror(crcerror), .far(far), .synbit(synbit), .synword(synword),
    .syndromevalid(syndromevalid), .clr(clr), .log_data(log_data), .log_valid(log_valid),
    .log_rdy(log_rdy), .log_full(log_full), .log_ovf(log_ovf), .single_cnt(single_cnt),
    .multi_cnt(multi_cnt), .crc_cnt(crc_cnt), .corr_req(corr_req), .corr_far(corr_far),
    .corr_word(corr_word), .corr_bit(corr_bit), .corr_ack(corr_ack), .corr_drop(corr_drop),
    .uncorr(uncorr));

  frame_ecc_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .eccerror(eccerror), .eccerrorsingle(eccerrorsingle),
    .crcerror(crcerror), .far(far), .synbit(synbit), .synword(synword),
    .syndromevalid(syndromevalid), .clr(clr), .log_data(d4_log_data), .log_valid(d4_log_valid),
    .log_rdy(log_rdy), .log_full(d4_log_full), .log_ovf(d4_log_ovf), .single_cnt(s4_cnt),
    .multi_cnt(d4_multi_cnt), .crc_cnt(d4_crc_cnt), .corr_req(d4_corr_req), .corr_far(d4_corr_far),
    .corr_word(d4_corr_word), .corr_bit(d4_corr_bit), .corr_ack(corr_ack), .corr_drop(d4_corr_drop),
    .uncorr(d4_uncorr));

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic s, input logic [25:0] f, input logic [6:0] w, input logic [4:0] b);
    syndromevalid = 1; eccerror = 1; eccerrorsingle = s; far = f; synword = w; synbit = b;
    tick();
    syndromevalid = 0; eccerror = 0; eccerrorsingle = 0;
  endtask

  function automatic logic [39:0] ent(input logic [1:0] t, input logic [25:0] f, input logic [6:0] w, input logic [4:0] b);
    return {t, f, w, b};
  endfunction

  initial begin
    tick(); tick();
    chk("rst_valid", log_valid, 0);
    chk("rst_data", log_data, 0);
    chk("rst_req", corr_req, 0);
    chk("rst_cnt", single_cnt, 0);
    rst_n = 1;
    tick();
    syndromevalid = 1; eccerror = 0; eccerrorsingle = 1;
    tick();
    syndromevalid = 0; eccerrorsingle = 0;
    chk("noecc_valid", log_valid, 0);
    chk("noecc_cnt", single_cnt, 0);
    ev(1, 26'h0001234, 7'd50, 5'd7);
    chk("s1_valid", log_valid, 1);
    chk("s1_data", log_data, ent(2'b01, 26'h0001234, 50, 7));
    chk("s1_cnt", single_cnt, 1);
    chk("s1_req", corr_req, 1);
    chk("s1_far", corr_far, 26'h0001234);
    chk("s1_word", corr_word, 50);
    chk("s1_bit", corr_bit, 7);
    ev(1, 26'h55, 7'd3, 5'd1);
    chk("drop_flag", corr_drop, 1);
    chk("drop_far", corr_far, 26'h0001234);
    chk("drop_word", corr_word, 50);
    chk("drop_cnt", single_cnt, 2);
    chk("drop_head", log_data, ent(2'b01, 26'h0001234, 50, 7));
    corr_ack = 1; tick(); corr_ack = 0;
    chk("ack_req", corr_req, 0);
    chk("ack_far_kept", corr_far, 26'h0001234);
    log_rdy = 1; tick();
    chk("pop1_head", log_data, ent(2'b01, 26'h55, 3, 1));
    tick();
    chk("pop2_empty", log_valid, 0);
    tick();
    chk("pop_empty_ign", log_valid, 0);
    chk("pop_empty_full", log_full, 0);
    log_rdy = 0;
    ev(0, 26'hABC, 7'd10, 5'd2);
    ev(1, 26'hDEF, 7'd101, 5'd4);
    chk("multi_cnt", multi_cnt, 2);
    chk("multi_uncorr", uncorr, 1);
    chk("multi_req", corr_req, 0);
    chk("multi_single", single_cnt, 2);
    chk("multi_head", log_data, ent(2'b10, 26'hABC, 10, 2));
    log_rdy = 1; tick();
    chk("inval_head", log_data, ent(2'b11, 26'hDEF, 101, 4));
    tick(); log_rdy = 0;
    chk("multi_empty", log_valid, 0);
    clr = 1; tick(); clr = 0;
    chk("clr_single", single_cnt, 0);
    chk("clr_uncorr", uncorr, 0);
    chk("clr_drop", corr_drop, 0);
    for (int i = 0; i < 9; i++) begin
      ev(1, 26'(i), 7'(i), 5'(i));
      if (i == 6) chk("fill7_full", log_full, 0);
      if (i == 7) chk("fill8_full", log_full, 1);
      if (i == 7) chk("fill8_ovf", log_ovf, 0);
    end
    chk("fill_ovf", log_ovf, 1);
    chk("fill_full", log_full, 1);
    chk("fill_cnt", single_cnt, 9);
    chk("fill_head", log_data, ent(2'b01, 0, 0, 0));
    corr_ack = 1; tick(); corr_ack = 0;
    clr = 1; tick(); clr = 0;
    chk("clr_ovf", log_ovf, 0);
    chk("clr_fifo_full", log_full, 1);
    log_rdy = 1;
    ev(1, 26'd9, 7'd9, 5'd9);
    chk("pp_full", log_full, 1);
    chk("pp_ovf", log_ovf, 0);
    for (int k = 0; k < 8; k++) begin
      chk("drain_head", log_data, (k < 7) ? ent(2'b01, 26'(k + 1), 7'(k + 1), 5'(k + 1)) : ent(2'b01, 9, 9, 9));
      tick();
    end
    log_rdy = 0;
    chk("drain_empty", log_valid, 0);
    for (int i = 0; i < 3; i++) begin
      crcerror = 1; tick(); tick();
      crcerror = 0; tick();
    end
    chk("crc_cnt", crc_cnt, 3);
    ev(0, 26'h77, 7'd7, 5'd7);
    ev(1, 26'h88, 7'd8, 5'd8);
    chk("pre_uncorr", uncorr, 1);
    chk("pre_drop", corr_drop, 1);
    corr_ack = 1; tick(); corr_ack = 0;
    clr = 1;
    ev(1, 26'h66, 7'd6, 5'd6);
    clr = 0;
    chk("clrev_single", single_cnt, 1);
    chk("clrev_multi", multi_cnt, 0);
    chk("clrev_crc", crc_cnt, 0);
    chk("clrev_uncorr", uncorr, 0);
    chk("clrev_drop", corr_drop, 0);
    chk("clrev_ovf", log_ovf, 0);
    chk("clrev_req", corr_req, 1);
    chk("clrev_far", corr_far, 26'h66);
    chk("clrev_head", log_data, ent(2'b10, 26'h77, 7, 7));
    clr = 1; tick(); clr = 0;
    log_rdy = 1;
    for (int i = 0; i < 20; i++) ev(1, 26'h100, 7'd1, 5'd1);
    log_rdy = 0;
    chk("sat16_cnt", single_cnt, 20);
    chk("sat4_cnt", s4_cnt, 15);
    chk("mid_req", corr_req, 1);
    #3 rst_n = 0;
    #1;
    chk("arst_req", corr_req, 0);
    chk("arst_far", corr_far, 0);
    chk("arst_valid", log_valid, 0);
    chk("arst_data", log_data, 0);
    chk("arst_cnt", single_cnt, 0);
    chk("arst_cnt4", s4_cnt, 0);
    tick();
    rst_n = 1;
    tick();
    chk("arst_idle", corr_req, 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
